// File: rtl/spi_pkg.sv
// Shared SPI definitions: serial-RAM opcodes, responder FSM states and the
// mode-0 timing constants also used by the CPU's SPI master.
package spi_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_RDID  = 8'h9F;

  // Mode 0: sck idles low, data sampled on rise, shifted on fall.
  localparam logic SPI_MODE0_CPOL          = 1'b0;
  localparam int   SPI_MODE0_MIN_HALF_CLKS = 4;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    RD_DATA,
    WR_DATA,
    RDID,
    IGNORE
  } state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Brings cs_n/sck/mosi into the clk domain and derives sck edges and the
// chip-select falling edge that opens a transaction.
module spi_edge_sync
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic spi_cs_n,
  input  logic spi_sck,
  input  logic spi_mosi,
  output logic sck_rise,
  output logic sck_fall,
  output logic cs_active,
  output logic cs_fall,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_prev;
  logic                   cs_n_prev;

  // Plain synchroniser chains; they keep tracking the pins through reset.
  always_ff @(posedge clk) begin
    cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
    sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
    mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
  end

  // cs_n_prev resets to "selected" so a chip select held low across reset
  // must go high and low again before it counts as a new frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_prev  <= SPI_MODE0_CPOL;
      cs_n_prev <= 1'b0;
    end else begin
      sck_prev  <= sck_sync[SYNC_STAGES-1];
      cs_n_prev <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sck_rise  = sck_sync[SYNC_STAGES-1] & ~sck_prev;
  assign sck_fall  = ~sck_sync[SYNC_STAGES-1] & sck_prev;
  assign cs_active = ~cs_sync[SYNC_STAGES-1];
  assign cs_fall   = cs_n_prev & ~cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];

endmodule

// File: rtl/spi_mem_responder.sv
// SPI mode-0 responder with a small byte-addressed scratch memory driven by
// serial-RAM READ/WRITE/RDID commands, fully oversampled on clk.
module spi_mem_responder
  import spi_pkg::*;
#(
  parameter int         DEPTH       = 16,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] ID_BYTE     = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     spi_cs_n,
  input  logic                     spi_sck,
  input  logic                     spi_mosi,
  output logic                     spi_miso,
  output logic                     spi_miso_oe,
  output logic                     wr_pulse,
  input  logic [$clog2(DEPTH)-1:0] dbg_addr,
  output logic [7:0]               dbg_data
);

  localparam int AW = $clog2(DEPTH);

  logic          sck_rise;
  logic          sck_fall;
  logic          cs_active;
  logic          cs_fall;
  logic          mosi_s;

  state_t        state;
  state_t        state_next;
  logic [2:0]    bit_cnt;
  logic [6:0]    rx_shift;
  logic [7:0]    tx_shift;
  logic [7:0]    rx_byte;
  logic [AW-1:0] addr;
  logic [AW-1:0] addr_inc;
  logic          rd_flag;
  logic          byte_done;
  logic [7:0]    mem [DEPTH];

  spi_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .spi_cs_n (spi_cs_n),
    .spi_sck  (spi_sck),
    .spi_mosi (spi_mosi),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .cs_active(cs_active),
    .cs_fall  (cs_fall),
    .mosi_s   (mosi_s)
  );

  assign rx_byte   = {rx_shift, mosi_s};
  assign byte_done = sck_rise && (bit_cnt == 3'd7);
  assign addr_inc  = addr + 1'b1;
  assign dbg_data  = mem[dbg_addr];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Deselect overrides everything, including a byte completing this clk.
  always_comb begin
    state_next = state;
    if (!cs_active) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (cs_fall) state_next = CMD;
        CMD: begin
          if (byte_done) begin
            if ((rx_byte == OP_READ) || (rx_byte == OP_WRITE)) state_next = ADDR;
            else if (rx_byte == OP_RDID)                       state_next = RDID;
            else                                               state_next = IGNORE;
          end
        end
        ADDR: if (byte_done) state_next = rd_flag ? RD_DATA : WR_DATA;
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      addr        <= '0;
      rd_flag     <= 1'b0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      wr_pulse    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      wr_pulse    <= 1'b0;
      spi_miso_oe <= cs_active;
      if (!cs_active || (state == IDLE)) begin
        bit_cnt  <= '0;
        rx_shift <= '0;
        spi_miso <= 1'b0;
      end else begin
        if (sck_rise) begin
          bit_cnt  <= bit_cnt + 3'd1;
          rx_shift <= {rx_shift[5:0], mosi_s};
        end
        if (byte_done) begin
          case (state)
            CMD: begin
              rd_flag <= (rx_byte == OP_READ);
              if (rx_byte == OP_RDID) tx_shift <= ID_BYTE;
            end
            ADDR: begin
              addr     <= rx_byte[AW-1:0];
              tx_shift <= mem[rx_byte[AW-1:0]];
            end
            RD_DATA: begin
              addr     <= addr_inc;
              tx_shift <= mem[addr_inc];
            end
            WR_DATA: begin
              mem[addr] <= rx_byte;
              wr_pulse  <= 1'b1;
              addr      <= addr_inc;
            end
            RDID:    tx_shift <= ID_BYTE;
            default: ;
          endcase
        end else if (sck_fall) begin
          // Only the two reply states ever put data on miso.
          if ((state == RD_DATA) || (state == RDID)) begin
            spi_miso <= tx_shift[7];
            tx_shift <= {tx_shift[6:0], 1'b0};
          end else begin
            spi_miso <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_mem_responder.sv
// Self-checking bench: directed vector table, hand-built corner sequences,
// then random transactions against a byte-array memory model.
module tb_spi_mem_responder;
  import spi_pkg::*;

  localparam int DEPTH = 16;
  localparam int HALF  = SPI_MODE0_MIN_HALF_CLKS + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_cs_n = 1'b1;
  logic       spi_sck = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic       wr_pulse;
  logic [3:0] dbg_addr = '0;
  logic [7:0] dbg_data;

  int compared   = 0;
  int mismatched = 0;
  int wr_count   = 0;

  logic [7:0] model_mem [DEPTH];

  typedef struct {
    logic [7:0]      op;
    logic [7:0]      addr;
    bit              has_addr;
    int              n;
    logic [3:0][7:0] data;
    logic [3:0][7:0] exp;
    int              pulses;
  } vec_t;

  vec_t vecs [10];

  spi_mem_responder #(
    .DEPTH(DEPTH), .SYNC_STAGES(2), .ID_BYTE(8'hA5)
  ) dut (
    .clk(clk), .rst(rst), .spi_cs_n(spi_cs_n), .spi_sck(spi_sck),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .wr_pulse(wr_pulse), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wr_pulse === 1'b1) wr_count++;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [3:0][7:0] pack4(input logic [7:0] b0, b1, b2, b3);
    return {b3, b2, b1, b0};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic check_mem(input int a, input logic [7:0] expected, input string name);
    dbg_addr = 4'(a);
    #1;
    checkOutput(name, {24'h0, dbg_data}, {24'h0, expected});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic spi_select();
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic spi_deselect();
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = tx[i];
      repeat (HALF) @(negedge clk);
      rx[i] = spi_miso;
      spi_sck = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask

  // One complete framed transaction; header-phase miso is OR-ed into hdr_rx.
  task automatic applyStimulus(input logic [7:0] op, input logic [7:0] addr,
                               input bit has_addr, input int n,
                               input logic [3:0][7:0] data,
                               output logic [3:0][7:0] rx, output int pulses,
                               output logic [7:0] hdr_rx);
    logic [7:0] b;
    int p0;
    p0 = wr_count;
    rx = '0;
    spi_select();
    checkOutput("oe_selected", {31'h0, spi_miso_oe}, 32'h1);
    xfer_bits(op, 8, b);
    hdr_rx = b;
    if (has_addr) begin
      xfer_bits(addr, 8, b);
      hdr_rx |= b;
    end
    for (int k = 0; k < n; k++) begin
      xfer_bits(data[k], 8, b);
      rx[k] = b;
    end
    spi_deselect();
    checkOutput("oe_deselected", {31'h0, spi_miso_oe}, 32'h0);
    pulses = wr_count - p0;
  endtask

  // Reference model: whole-transaction semantics from the command set.
  task automatic model_txn(input logic [7:0] op, input logic [7:0] addr, input int n,
                           input logic [3:0][7:0] data, output logic [3:0][7:0] exp,
                           output int pulses);
    int a;
    a = addr % DEPTH;
    exp = '0;
    pulses = 0;
    for (int k = 0; k < n; k++) begin
      if (op == OP_WRITE) begin
        model_mem[(a + k) % DEPTH] = data[k];
        pulses++;
      end else if (op == OP_READ) begin
        exp[k] = model_mem[(a + k) % DEPTH];
      end else if (op == OP_RDID) begin
        exp[k] = 8'hA5;
      end
    end
  endtask

  initial begin
    logic [3:0][7:0] rx;
    logic [3:0][7:0] exp;
    logic [3:0][7:0] data;
    logic [7:0]      hdr;
    logic [7:0]      b;
    logic [7:0]      op;
    int              pulses;
    int              exp_pulses;
    int              p0;

    vecs[0] = '{8'h02, 8'h03, 1'b1, 3, pack4(8'h11, 8'h22, 8'h33, 8'h00), '0, 3};
    vecs[1] = '{8'h03, 8'h03, 1'b1, 3, '0, pack4(8'h11, 8'h22, 8'h33, 8'h00), 0};
    vecs[2] = '{8'h02, 8'h0E, 1'b1, 3, pack4(8'hAA, 8'hBB, 8'hCC, 8'h00), '0, 3};
    vecs[3] = '{8'h03, 8'h0E, 1'b1, 3, '0, pack4(8'hAA, 8'hBB, 8'hCC, 8'h00), 0};
    vecs[4] = '{8'h9F, 8'h00, 1'b0, 2, '0, pack4(8'hA5, 8'hA5, 8'h00, 8'h00), 0};
    vecs[5] = '{8'h5A, 8'h00, 1'b0, 1, pack4(8'hFF, 8'h00, 8'h00, 8'h00), '0, 0};
    vecs[6] = '{8'h03, 8'h13, 1'b1, 1, '0, pack4(8'h11, 8'h00, 8'h00, 8'h00), 0};
    vecs[7] = '{8'h02, 8'hF7, 1'b1, 1, pack4(8'h5C, 8'h00, 8'h00, 8'h00), '0, 1};
    vecs[8] = '{8'h03, 8'h07, 1'b1, 2, '0, pack4(8'h5C, 8'h00, 8'h00, 8'h00), 0};
    vecs[9] = '{8'h03, 8'h0F, 1'b1, 4, '0, pack4(8'hBB, 8'hCC, 8'h00, 8'h00), 0};

    do_reset();
    checkOutput("rst_miso", {31'h0, spi_miso}, 32'h0);
    checkOutput("rst_oe", {31'h0, spi_miso_oe}, 32'h0);
    checkOutput("rst_wr_pulse", {31'h0, wr_pulse}, 32'h0);

    // Deselected: sck activity must be ignored entirely.
    for (int e = 0; e < 16; e++) begin
      spi_mosi = 1'($urandom);
      spi_sck  = ~spi_sck;
      repeat (HALF) @(negedge clk);
      checkOutput("idle_miso", {31'h0, spi_miso}, 32'h0);
      checkOutput("idle_oe", {31'h0, spi_miso_oe}, 32'h0);
    end
    checkOutput("idle_wr_count", wr_count, 0);
    for (int a = 0; a < DEPTH; a++) check_mem(a, 8'h00, "idle_mem");

    for (int v = 0; v < 10; v++) begin
      applyStimulus(vecs[v].op, vecs[v].addr, vecs[v].has_addr, vecs[v].n,
                    vecs[v].data, rx, pulses, hdr);
      checkOutput("vec_hdr_miso", {24'h0, hdr}, 32'h0);
      for (int k = 0; k < vecs[v].n; k++)
        checkOutput($sformatf("vec%0d_byte%0d", v, k), {24'h0, rx[k]}, {24'h0, vecs[v].exp[k]});
      checkOutput($sformatf("vec%0d_pulses", v), pulses, vecs[v].pulses);
    end
    check_mem(3, 8'h11, "burst_mem3");
    check_mem(4, 8'h22, "burst_mem4");
    check_mem(5, 8'h33, "burst_mem5");
    check_mem(0, 8'hCC, "wrap_mem0");

    // Abort mid-byte: a partial data byte must never be committed.
    p0 = wr_count;
    spi_select();
    xfer_bits(8'h02, 8, b);
    xfer_bits(8'h07, 8, b);
    xfer_bits(8'hFF, 5, b);
    spi_deselect();
    checkOutput("abort_pulses", wr_count - p0, 0);
    check_mem(7, 8'h5C, "abort_mem7");
    applyStimulus(8'h02, 8'h07, 1'b1, 1, pack4(8'h44, 8'h00, 8'h00, 8'h00), rx, pulses, hdr);
    checkOutput("rewrite_pulses", pulses, 1);
    check_mem(7, 8'h44, "rewrite_mem7");

    // Reset in the middle of a read, with cs_n still held low afterwards.
    spi_select();
    xfer_bits(8'h03, 8, b);
    xfer_bits(8'h00, 8, b);
    xfer_bits(8'h00, 3, b);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstmid_miso", {31'h0, spi_miso}, 32'h0);
    checkOutput("rstmid_oe", {31'h0, spi_miso_oe}, 32'h0);
    rst = 1'b0;
    p0 = wr_count;
    hdr = '0;
    xfer_bits(8'h02, 8, b); hdr |= b;
    xfer_bits(8'h01, 8, b); hdr |= b;
    xfer_bits(8'h77, 8, b); hdr |= b;
    spi_deselect();
    checkOutput("rstmid_ignored_miso", {24'h0, hdr}, 32'h0);
    checkOutput("rstmid_ignored_pulses", wr_count - p0, 0);
    check_mem(1, 8'h00, "rstmid_mem1");
    check_mem(0, 8'h00, "rstmid_cleared_mem0");
    applyStimulus(8'h02, 8'h01, 1'b1, 1, pack4(8'h77, 8'h00, 8'h00, 8'h00), rx, pulses, hdr);
    checkOutput("reselect_pulses", pulses, 1);
    check_mem(1, 8'h77, "reselect_mem1");

    // Random transactions against the model, starting from a cleared memory.
    do_reset();
    for (int a = 0; a < DEPTH; a++) model_mem[a] = 8'h00;
    for (int t = 0; t < 24; t++) begin
      case ($urandom_range(0, 3))
        0:       op = OP_WRITE;
        1:       op = OP_READ;
        2:       op = OP_RDID;
        default: begin
          op = 8'($urandom_range(0, 255));
          while (op == OP_WRITE || op == OP_READ || op == OP_RDID) op = 8'($urandom_range(0, 255));
        end
      endcase
      b = 8'($urandom_range(0, 255));
      data = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
      p0 = $urandom_range(1, 4);
      model_txn(op, b, p0, data, exp, exp_pulses);
      applyStimulus(op, b, (op == OP_WRITE || op == OP_READ), p0, data, rx, pulses, hdr);
      checkOutput("rnd_hdr_miso", {24'h0, hdr}, 32'h0);
      for (int k = 0; k < p0; k++)
        checkOutput($sformatf("rnd%0d_op%0h_byte%0d", t, op, k), {24'h0, rx[k]}, {24'h0, exp[k]});
      checkOutput($sformatf("rnd%0d_pulses", t), pulses, exp_pulses);
      b = 8'($urandom_range(0, DEPTH - 1));
      check_mem(int'(b), model_mem[b[3:0]], "rnd_mem");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
